ddc_mixdec: RTL and testbench

DDC_MIXDEC -- requirements
Module: ddc_mixdec

---
 rtl/ddc_pkg.sv | 34 +++
 rtl/ddc_mixdec_if.sv | 36 +++
 rtl/nco_lut.sv | 46 ++++
 rtl/ddc_mixdec.sv | 276 +++++++++++++++++++++++++++
 tb/tb_ddc_mixdec.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/ddc_pkg.sv
// Shared constants, types and helpers for the digital down-converter slice.
// Holds power-on config defaults, the flush length, the control FSM state
// type and an elaboration-time ceil(log2) helper.
package ddc_pkg;

    // Config port widths
    localparam int unsigned DEC_W   = 7;
    localparam int unsigned SHIFT_W = 6;

    // fs/4 tuning word, MSB-aligned so any phase width can take its top bits
    localparam logic [63:0]        DEF_FREQ  = 64'h4000_0000_0000_0000;
    localparam logic [DEC_W-1:0]   DEF_DEC   = 7'd4;
    localparam logic [SHIFT_W-1:0] DEF_SHIFT = 6'd0;

    // Cycles spent discarding input after reset or a config load
    localparam int unsigned FLUSH_CYC = 4;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } ddc_state_e;

    // ceil(log2(v)); clog2(1) = 0
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r = 0;
        longint unsigned x = 1;
        while (x < longint'(v)) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ddc_mixdec_if.sv
// Sample/config/result bundle for ddc_mixdec.
// Inputs:  in_valid, data_in, cfg_load, cfg_freq, cfg_dec, cfg_shift
// Outputs: out_valid, data_out_i, data_out_q, out_sat, sat_sticky
// master = sample source / config owner, slave = the down-converter.
interface ddc_mixdec_if
    import ddc_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned PHASE_W = 32
) ();

    logic                      in_valid;
    logic signed [DATA_W-1:0]  data_in;
    logic                      cfg_load;
    logic [PHASE_W-1:0]        cfg_freq;
    logic [DEC_W-1:0]          cfg_dec;
    logic [SHIFT_W-1:0]        cfg_shift;

    logic                      out_valid;
    logic signed [OUT_W-1:0]   data_out_i;
    logic signed [OUT_W-1:0]   data_out_q;
    logic                      out_sat;
    logic                      sat_sticky;

    modport master (
        output in_valid, data_in, cfg_load, cfg_freq, cfg_dec, cfg_shift,
        input  out_valid, data_out_i, data_out_q, out_sat, sat_sticky
    );

    modport slave (
        input  in_valid, data_in, cfg_load, cfg_freq, cfg_dec, cfg_shift,
        output out_valid, data_out_i, data_out_q, out_sat, sat_sticky
    );

endinterface

// File: rtl/nco_lut.sv
// Full-cycle cos/sin ROM for the NCO with a registered read.
// Entry a holds round(A*cos(2*pi*a/2^LUT_AW)) and the matching sin, with
// A = 2^(DATA_W-1)-1. The table is fixed at elaboration.
// Ports: clk_ddc, addr (LUT_AW) in; cos_q, sin_q (signed DATA_W) out, one
// cycle after addr.
module nco_lut #(
    parameter int unsigned LUT_AW = 10,
    parameter int unsigned DATA_W = 16
) (
    input  logic                     clk_ddc,
    input  logic [LUT_AW-1:0]        addr,
    output logic signed [DATA_W-1:0] cos_q,
    output logic signed [DATA_W-1:0] sin_q
);

    localparam int unsigned DEPTH  = 1 << LUT_AW;
    localparam real         TWO_PI = 6.283185307179586;
    localparam real         AMP    = $itor((1 << (DATA_W - 1)) - 1);

    logic signed [DATA_W-1:0] cos_tab [DEPTH];
    logic signed [DATA_W-1:0] sin_tab [DEPTH];
    logic signed [DATA_W-1:0] cos_d;
    logic signed [DATA_W-1:0] sin_d;

    // Round-to-nearest, symmetric about zero
    for (genvar a = 0; a < DEPTH; a++) begin : g_tab
        localparam real ANG   = TWO_PI * $itor(a) / $itor(DEPTH);
        localparam real COS_R = $cos(ANG) * AMP;
        localparam real SIN_R = $sin(ANG) * AMP;
        localparam int  COS_V = (COS_R >= 0.0) ? $rtoi(COS_R + 0.5) : -$rtoi(0.5 - COS_R);
        localparam int  SIN_V = (SIN_R >= 0.0) ? $rtoi(SIN_R + 0.5) : -$rtoi(0.5 - SIN_R);
        assign cos_tab[a] = DATA_W'(COS_V);
        assign sin_tab[a] = DATA_W'(SIN_V);
    end

    always_comb begin
        cos_d = cos_tab[addr];
        sin_d = sin_tab[addr];
    end

    always_ff @(posedge clk_ddc) begin
        cos_q <= cos_d;
        sin_q <= sin_d;
    end

endmodule

// File: rtl/ddc_mixdec.sv
// NCO mixer + integrate-and-dump decimator.
// Each accepted sample is multiplied by the NCO cos (I) and sin (Q); every
// dec accepted samples the sums are shifted right (floor), saturated and
// presented with a one-cycle out_valid, 4 cycles after the last sample.
// Ports: clk_ddc, reset_n (synchronous, active-low), bus (slave modport):
//   in_valid/data_in sample stream, cfg_load/cfg_freq/cfg_dec/cfg_shift
//   config, out_valid/data_out_i/data_out_q/out_sat/sat_sticky results.
module ddc_mixdec
    import ddc_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned LUT_AW  = 10,
    parameter int unsigned DEC_MAX = 64
) (
    input  logic         clk_ddc,
    input  logic         reset_n,
    ddc_mixdec_if.slave  bus
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned ACC_W  = PROD_W + clog2(DEC_MAX);
    localparam int unsigned FC_W   = clog2(FLUSH_CYC);

    // ---------------- control FSM ----------------
    ddc_state_e      state_q, state_d;
    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic            accept_c;
    logic            run_c;

    // State register
    always_ff @(posedge clk_ddc) begin
        if (!reset_n) begin
            state_q <= ST_FLUSH;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Next state: a load restarts the flush from any state
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (bus.cfg_load) begin
            state_d = ST_FLUSH;
            fcnt_d  = '0;
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    if (fcnt_q == FC_W'(FLUSH_CYC - 1)) state_d = ST_RUN;
                    else                                fcnt_d  = fcnt_q + FC_W'(1);
                end
                default: ;
            endcase
        end
    end

    // FSM decode: a load outranks a coincident sample
    always_comb begin
        run_c    = 1'b0;
        accept_c = 1'b0;
        if (state_q == ST_RUN) begin
            run_c    = 1'b1;
            accept_c = bus.in_valid && !bus.cfg_load;
        end
    end

    // ---------------- datapath registers ----------------
    logic [PHASE_W-1:0]       freq_q, freq_d;
    logic [DEC_W-1:0]         dec_q, dec_d;
    logic [SHIFT_W-1:0]       shift_q, shift_d;
    logic [PHASE_W-1:0]       phase_q, phase_d;
    logic [DEC_W-1:0]         cnt_q, cnt_d;

    logic                     v1_q, v1_d, last1_q, last1_d;
    logic [LUT_AW-1:0]        addr_q, addr_d;
    logic signed [DATA_W-1:0] d1_q, d1_d;

    logic                     v2_q, v2_d, last2_q, last2_d;
    logic signed [DATA_W-1:0] d2_q, d2_d;
    logic signed [DATA_W-1:0] lut_cos, lut_sin;

    logic                     v3_q, v3_d, last3_q, last3_d;
    logic signed [PROD_W-1:0] prod_i_q, prod_i_d, prod_q_q, prod_q_d;

    logic signed [ACC_W-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic signed [ACC_W-1:0]  dump_i_q, dump_i_d, dump_q_q, dump_q_d;
    logic                     dump_v_q, dump_v_d;

    logic                     out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0]  data_out_i_q, data_out_i_d, data_out_q_q, data_out_q_d;
    logic                     out_sat_q, out_sat_d;
    logic                     sat_sticky_q, sat_sticky_d;

    logic signed [ACC_W-1:0]  sum_i_c, sum_q_c, sh_i_c, sh_q_c;
    logic [OUT_W:0]           sat_i_c, sat_q_c;

    // {overflow, value}: clamp to the signed OUT_W range
    function automatic logic [OUT_W:0] sat_fn(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-OUT_W:0] hi;
        hi = v[ACC_W-1:OUT_W-1];
        if ((&hi) || !(|hi)) return {1'b0, v[OUT_W-1:0]};
        else if (v[ACC_W-1]) return {1'b1, 1'b1, {(OUT_W - 1){1'b0}}};
        else                 return {1'b1, 1'b0, {(OUT_W - 1){1'b1}}};
    endfunction

    nco_lut #(
        .LUT_AW (LUT_AW),
        .DATA_W (DATA_W)
    ) u_nco_lut (
        .clk_ddc (clk_ddc),
        .addr    (addr_q),
        .cos_q   (lut_cos),
        .sin_q   (lut_sin)
    );

    // Shadow config, NCO phase and decimation count
    always_comb begin
        freq_d  = freq_q;
        dec_d   = dec_q;
        shift_d = shift_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        v1_d    = 1'b0;
        last1_d = 1'b0;
        addr_d  = addr_q;
        d1_d    = d1_q;
        if (bus.cfg_load) begin
            freq_d  = bus.cfg_freq;
            shift_d = bus.cfg_shift;
            if (bus.cfg_dec == '0)                dec_d = DEC_W'(1);
            else if (32'(bus.cfg_dec) > DEC_MAX)  dec_d = DEC_W'(DEC_MAX);
            else                                  dec_d = bus.cfg_dec;
            phase_d = '0;
            cnt_d   = '0;
        end else if (accept_c) begin
            // Sample is mixed with the phase before this advance
            v1_d    = 1'b1;
            d1_d    = bus.data_in;
            addr_d  = phase_q[PHASE_W-1 -: LUT_AW];
            phase_d = phase_q + freq_q;
            if (cnt_q == dec_q - DEC_W'(1)) begin
                last1_d = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + DEC_W'(1);
            end
        end
    end

    // Align data with table output, then multiply
    always_comb begin
        v2_d     = v1_q && !bus.cfg_load;
        last2_d  = last1_q;
        d2_d     = d1_q;
        v3_d     = v2_q && !bus.cfg_load;
        last3_d  = last2_q;
        prod_i_d = PROD_W'(d2_q) * PROD_W'(lut_cos);
        prod_q_d = PROD_W'(d2_q) * PROD_W'(lut_sin);
    end

    // Integrate; the dumping sample closes the sum and the next one starts fresh
    always_comb begin
        sum_i_c  = acc_i_q + ACC_W'(prod_i_q);
        sum_q_c  = acc_q_q + ACC_W'(prod_q_q);
        acc_i_d  = acc_i_q;
        acc_q_d  = acc_q_q;
        dump_i_d = dump_i_q;
        dump_q_d = dump_q_q;
        dump_v_d = 1'b0;
        if (bus.cfg_load) begin
            acc_i_d = '0;
            acc_q_d = '0;
        end else if (v3_q) begin
            if (last3_q) begin
                dump_v_d = 1'b1;
                dump_i_d = sum_i_c;
                dump_q_d = sum_q_c;
                acc_i_d  = '0;
                acc_q_d  = '0;
            end else begin
                acc_i_d  = sum_i_c;
                acc_q_d  = sum_q_c;
            end
        end
    end

    // Floor shift, saturate, and hold results between strobes
    always_comb begin
        sh_i_c       = dump_i_q >>> shift_q;
        sh_q_c       = dump_q_q >>> shift_q;
        sat_i_c      = sat_fn(sh_i_c);
        sat_q_c      = sat_fn(sh_q_c);
        out_valid_d  = dump_v_q && run_c && !bus.cfg_load;
        data_out_i_d = data_out_i_q;
        data_out_q_d = data_out_q_q;
        out_sat_d    = out_sat_q;
        sat_sticky_d = sat_sticky_q;
        if (out_valid_d) begin
            data_out_i_d = sat_i_c[OUT_W-1:0];
            data_out_q_d = sat_q_c[OUT_W-1:0];
            out_sat_d    = sat_i_c[OUT_W] | sat_q_c[OUT_W];
            sat_sticky_d = sat_sticky_q | sat_i_c[OUT_W] | sat_q_c[OUT_W];
        end
        if (bus.cfg_load) sat_sticky_d = 1'b0;
    end

    // Datapath state
    always_ff @(posedge clk_ddc) begin
        if (!reset_n) begin
            freq_q       <= DEF_FREQ[63 -: PHASE_W];
            dec_q        <= DEF_DEC;
            shift_q      <= DEF_SHIFT;
            phase_q      <= '0;
            cnt_q        <= '0;
            v1_q         <= 1'b0;
            last1_q      <= 1'b0;
            addr_q       <= '0;
            d1_q         <= '0;
            v2_q         <= 1'b0;
            last2_q      <= 1'b0;
            d2_q         <= '0;
            v3_q         <= 1'b0;
            last3_q      <= 1'b0;
            prod_i_q     <= '0;
            prod_q_q     <= '0;
            acc_i_q      <= '0;
            acc_q_q      <= '0;
            dump_i_q     <= '0;
            dump_q_q     <= '0;
            dump_v_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            data_out_i_q <= '0;
            data_out_q_q <= '0;
            out_sat_q    <= 1'b0;
            sat_sticky_q <= 1'b0;
        end else begin
            freq_q       <= freq_d;
            dec_q        <= dec_d;
            shift_q      <= shift_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            v1_q         <= v1_d;
            last1_q      <= last1_d;
            addr_q       <= addr_d;
            d1_q         <= d1_d;
            v2_q         <= v2_d;
            last2_q      <= last2_d;
            d2_q         <= d2_d;
            v3_q         <= v3_d;
            last3_q      <= last3_d;
            prod_i_q     <= prod_i_d;
            prod_q_q     <= prod_q_d;
            acc_i_q      <= acc_i_d;
            acc_q_q      <= acc_q_d;
            dump_i_q     <= dump_i_d;
            dump_q_q     <= dump_q_d;
            dump_v_q     <= dump_v_d;
            out_valid_q  <= out_valid_d;
            data_out_i_q <= data_out_i_d;
            data_out_q_q <= data_out_q_d;
            out_sat_q    <= out_sat_d;
            sat_sticky_q <= sat_sticky_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.data_out_i = data_out_i_q;
    assign bus.data_out_q = data_out_q_q;
    assign bus.out_sat    = out_sat_q;
    assign bus.sat_sticky = sat_sticky_q;

endmodule

// File: tb/tb_ddc_mixdec.sv
// Scoreboard bench for ddc_mixdec: a behavioural model predicts each
// decimated result and its strobe cycle when the samples are driven; the
// monitor pops and compares on every out_valid.
module tb_ddc_mixdec;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned OUT_W   = 16;
    localparam int unsigned PHASE_W = 32;
    localparam int unsigned LUT_AW  = 10;
    localparam int unsigned DEC_MAX = 64;

    typedef struct {
        int     due;
        longint i;
        longint q;
        bit     sat;
        bit     sticky;
    } exp_t;

    logic clk_ddc = 1'b0;
    logic reset_n;

    ddc_mixdec_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .PHASE_W(PHASE_W)) bus ();

    ddc_mixdec #(
        .DATA_W  (DATA_W),
        .OUT_W   (OUT_W),
        .PHASE_W (PHASE_W),
        .LUT_AW  (LUT_AW),
        .DEC_MAX (DEC_MAX)
    ) dut (
        .clk_ddc (clk_ddc),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_ddc = ~clk_ddc;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    exp_t        sb[$];
    int          cos_t[1024];
    int          sin_t[1024];

    // Reference model state
    logic [31:0] m_phase, m_freq;
    int          m_dec, m_shift, m_cnt, m_flush;
    longint      m_acc_i, m_acc_q;
    bit          m_sticky;

    // Config presented on the next load
    logic [31:0] c_freq;
    int          c_dec, c_shift;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint sat16(input longint x, output bit s);
        s = 1'b0;
        if (x > 32767)       begin s = 1'b1; return 32767;  end
        else if (x < -32768) begin s = 1'b1; return -32768; end
        return x;
    endfunction

    task automatic model_clear();
        m_phase = '0; m_cnt = 0; m_acc_i = 0; m_acc_q = 0;
        m_flush = 4; m_sticky = 1'b0;
    endtask

    // Model one rising edge with the inputs that edge captures
    task automatic model_edge(input bit rst, input bit ld, input bit v, input int d);
        exp_t e;
        bit   si, sq;
        int   a;
        if (rst) begin
            m_freq = 32'h4000_0000; m_dec = 4; m_shift = 0;
            model_clear();
            sb.delete();
            return;
        end
        if (ld) begin
            m_freq  = c_freq;
            m_dec   = (c_dec == 0) ? 1 : ((c_dec > 64) ? 64 : c_dec);
            m_shift = c_shift;
            model_clear();
            while (sb.size() > 0 && sb[$].due >= cyc) void'(sb.pop_back());
            return;
        end
        if (m_flush > 0) begin
            m_flush--;
            return;
        end
        if (!v) return;
        a = int'(m_phase[31:22]);
        m_acc_i += longint'(d) * longint'(cos_t[a]);
        m_acc_q += longint'(d) * longint'(sin_t[a]);
        m_phase += m_freq;
        m_cnt++;
        if (m_cnt == m_dec) begin
            e.due    = cyc + 4;
            e.i      = sat16(m_acc_i >>> m_shift, si);
            e.q      = sat16(m_acc_q >>> m_shift, sq);
            e.sat    = si | sq;
            m_sticky = m_sticky | e.sat;
            e.sticky = m_sticky;
            sb.push_back(e);
            m_acc_i = 0; m_acc_q = 0; m_cnt = 0;
        end
    endtask

    task automatic tick(input bit rst, input bit ld, input bit v, input int d);
        reset_n       = !rst;
        bus.cfg_load  = ld;
        bus.in_valid  = v;
        bus.data_in   = 16'(d);
        bus.cfg_freq  = c_freq;
        bus.cfg_dec   = 7'(c_dec);
        bus.cfg_shift = 6'(c_shift);
        @(posedge clk_ddc);
        cyc++;
        model_edge(rst, ld, v, d);
        #1;
    endtask

    task automatic load(input logic [31:0] f, input int dc, input int sh, input bit v, input int d);
        c_freq = f; c_dec = dc; c_shift = sh;
        tick(1'b0, 1'b1, v, d);
    endtask

    task automatic check_zero_outputs(input string pfx);
        check_eq({pfx, "_valid"},  longint'(bus.out_valid),  0);
        check_eq({pfx, "_i"},      longint'(bus.data_out_i), 0);
        check_eq({pfx, "_q"},      longint'(bus.data_out_q), 0);
        check_eq({pfx, "_sat"},    longint'(bus.out_sat),    0);
        check_eq({pfx, "_sticky"}, longint'(bus.sat_sticky), 0);
    endtask

    // Scoreboard monitor, half a cycle after each edge
    always @(negedge clk_ddc) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            check_eq("missed_strobe_due", longint'(cyc), longint'(e.due));
        end
        if (bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("spurious_strobe", 1, 0);
            end else begin
                e = sb.pop_front();
                check_eq("strobe_edge", longint'(cyc),            longint'(e.due));
                check_eq("out_i",       longint'(bus.data_out_i), e.i);
                check_eq("out_q",       longint'(bus.data_out_q), e.q);
                check_eq("out_sat",     longint'(bus.out_sat),    longint'(e.sat));
                check_eq("sat_sticky",  longint'(bus.sat_sticky), longint'(e.sticky));
            end
        end
    end

    initial begin
        real r;
        for (int k = 0; k < 1024; k++) begin
            r = $cos(6.283185307179586 * $itor(k) / 1024.0) * 32767.0;
            cos_t[k] = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
            r = $sin(6.283185307179586 * $itor(k) / 1024.0) * 32767.0;
            sin_t[k] = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
        end
        c_freq = '0; c_dec = 4; c_shift = 0;

        // Reset state
        tick(1'b1, 1'b0, 1'b0, 0);
        tick(1'b1, 1'b0, 1'b0, 0);
        check_zero_outputs("reset");

        // Defaults: fs/4 mix of DC cancels over 4 samples
        repeat (24) tick(1'b0, 1'b0, 1'b1, 1000);

        // DC at zero frequency, floor shift: 4*1000*32767 >>> 17 = 999
        load(32'h0, 4, 17, 1'b0, 0);
        repeat (20) tick(1'b0, 1'b0, 1'b1, 1000);

        // Positive then negative full-scale saturation with dec = 64
        load(32'h0, 64, 0, 1'b0, 0);
        repeat (68) tick(1'b0, 1'b0, 1'b1, 32767);
        repeat (6)  tick(1'b0, 1'b0, 1'b0, 0);
        check_eq("sticky_set", longint'(bus.sat_sticky), 1);
        repeat (64) tick(1'b0, 1'b0, 1'b1, -32768);
        repeat (6)  tick(1'b0, 1'b0, 1'b0, 0);

        // Load clears sticky; partial sum abandoned; flush samples ignored
        load(32'h0, 4, 17, 1'b1, 1000);
        check_eq("sticky_clr", longint'(bus.sat_sticky), 0);
        repeat (4) tick(1'b0, 1'b0, 1'b1, 1000);
        repeat (3) tick(1'b0, 1'b0, 1'b1, 500);
        load(32'h0, 4, 17, 1'b1, 1000);
        repeat (4) tick(1'b0, 1'b0, 1'b1, 2000);
        repeat (4) tick(1'b0, 1'b0, 1'b1, 1000);
        repeat (6) tick(1'b0, 1'b0, 1'b0, 0);

        // dec = 5: continuous, then alternate-cycle input
        load(32'h1357_9BDF, 5, 16, 1'b0, 0);
        repeat (4)  tick(1'b0, 1'b0, 1'b0, 0);
        repeat (20) tick(1'b0, 1'b0, 1'b1, int'($urandom_range(65535, 0)) - 32768);
        for (int k = 0; k < 40; k++)
            tick(1'b0, 1'b0, bit'(k % 2 == 0), int'($urandom_range(65535, 0)) - 32768);
        repeat (6) tick(1'b0, 1'b0, 1'b0, 0);

        // One-cycle reset in the middle of a sum
        load(32'h0, 4, 17, 1'b0, 0);
        repeat (10) tick(1'b0, 1'b0, 1'b1, 1000);
        tick(1'b1, 1'b0, 1'b1, 1000);
        check_zero_outputs("midreset");
        repeat (12) tick(1'b0, 1'b0, 1'b1, 1000);
        repeat (6)  tick(1'b0, 1'b0, 1'b0, 0);

        // Random tuning, gapped input, clamped decimation factors
        for (int t = 0; t < 6; t++) begin
            int dl [6];
            dl = '{0, 1, 3, 8, 100, 7};
            load($urandom, dl[t], int'($urandom_range(20, 12)), 1'b0, 0);
            repeat (140) tick(1'b0, 1'b0, bit'($urandom_range(3, 0) != 0),
                              int'($urandom_range(65535, 0)) - 32768);
        end

        repeat (10) tick(1'b0, 1'b0, 1'b0, 0);
        check_eq("sb_empty", longint'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
